// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
// Segment patterns are active-low, with DP in bit 7.
package seg_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int SEG_W      = 8;

   localparam logic [SEG_W-1:0]      SEG_BLANK  = 8'hFF;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF    = 6'h3F;
   localparam logic [2:0]            LAST_DIGIT = 3'd5;

   typedef enum logic {BLANK, SHOW} scan_state_t;

   typedef logic [SEG_W-1:0]            seg_t;
   typedef logic [NUM_DIGITS*SEG_W-1:0] frame_t;
   typedef logic [NUM_DIGITS-1:0]       dig_t;

   // Byte for one digit; indices beyond the last digit read as blank
   function automatic seg_t seg_pick(frame_t f, logic [2:0] idx);
      seg_t r;
      r = SEG_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (idx == 3'(i)) r = f[i*SEG_W +: SEG_W];
      return r;
   endfunction

   // Active-low one-hot enable for one digit
   function automatic dig_t dig_sel_n(logic [2:0] idx);
      dig_t r;
      r = DIG_OFF;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (idx == 3'(i)) r[i] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_driver_timer.sv
// Slot timer: blank/show sequencing, digit rotation and PWM phase.
// Exposes next-cycle decode so the top can register its outputs.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_brightness,
   output logic       o_show_nxt,
   output logic       o_pwm_on_nxt,
   output logic [2:0] o_digit_nxt,
   output logic       o_frame_last
);

   localparam int CW = $clog2(DIGIT_CYCLES);
   localparam logic [CW-1:0] SLOT_END  = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

   scan_state_t   r_state, w_state_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic [3:0]    r_pwm, w_pwm_n;
   logic [3:0]    r_lvl, w_lvl_n;
   logic [2:0]    r_digit, w_digit_n;
   logic          r_frame_last, w_frame_last_n;
   logic          w_slot_last;

   // Next-state decode for the slot sequence and PWM phase
   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt + 1'b1;
      w_pwm_n     = r_pwm;
      w_lvl_n     = r_lvl;
      w_digit_n   = r_digit;
      w_slot_last = (r_cnt == SLOT_END);
      unique case (r_state)
         BLANK: begin
            if (r_cnt == BLANK_END) begin
               w_state_n = SHOW;
               w_pwm_n   = 4'd0;
               w_lvl_n   = i_brightness;
            end
         end
         SHOW: begin
            w_pwm_n = r_pwm + 4'd1;
            if (w_slot_last) begin
               w_state_n = BLANK;
               w_cnt_n   = '0;
               w_digit_n = (r_digit == LAST_DIGIT) ?
                           3'd0 : r_digit + 3'd1;
            end
         end
         default: w_state_n = BLANK;
      endcase
      w_frame_last_n = (w_cnt_n == SLOT_END) &&
                       (w_digit_n == LAST_DIGIT);
   end

   // Slot state registers; reset is cycle 0 of digit 0's blank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= BLANK;
         r_cnt        <= '0;
         r_pwm        <= 4'd0;
         r_lvl        <= 4'd0;
         r_digit      <= 3'd0;
         r_frame_last <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_cnt        <= w_cnt_n;
         r_pwm        <= w_pwm_n;
         r_lvl        <= w_lvl_n;
         r_digit      <= w_digit_n;
         r_frame_last <= w_frame_last_n;
      end
   end

   assign o_show_nxt   = (w_state_n == SHOW);
   assign o_pwm_on_nxt = (w_lvl_n == 4'hF) || (w_pwm_n < w_lvl_n);
   assign o_digit_nxt  = w_digit_n;
   assign o_frame_last = r_frame_last;

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with double-buffered
// frames, anti-ghost blanking and 4-bit PWM brightness.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] display_bits,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [3:0]  brightness,
   output logic [7:0]  seg_n,
   output logic [5:0]  dig_en_n,
   output logic        frame_done
);

   frame_t     r_active;
   frame_t     r_pend;
   logic       r_pend_v;
   seg_t       r_seg;
   dig_t       r_dig;

   logic       w_show_nxt;
   logic       w_pwm_on_nxt;
   logic [2:0] w_digit_nxt;
   logic       w_frame_last;
   logic       w_accept;
   logic       w_en_nxt;

   seg_slot_timer #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_brightness (brightness),
      .o_show_nxt   (w_show_nxt),
      .o_pwm_on_nxt (w_pwm_on_nxt),
      .o_digit_nxt  (w_digit_nxt),
      .o_frame_last (w_frame_last)
   );

   assign w_accept = load_valid && !r_pend_v;
   assign w_en_nxt = w_show_nxt && w_pwm_on_nxt;

   // Frame double buffer; promotion happens only at the frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= '1;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
      end else begin
         if (w_frame_last && r_pend_v) begin
            r_active <= r_pend;
            r_pend_v <= 1'b0;
         end
         if (w_accept) begin
            r_pend   <= display_bits;
            r_pend_v <= 1'b1;
         end
      end
   end

   // Output flops loaded from next-cycle decode so pins track the state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= SEG_BLANK;
         r_dig <= DIG_OFF;
      end else if (w_en_nxt) begin
         r_seg <= seg_pick(r_active, w_digit_nxt);
         r_dig <= dig_sel_n(w_digit_nxt);
      end else begin
         r_seg <= SEG_BLANK;
         r_dig <= DIG_OFF;
      end
   end

   assign load_ready = !r_pend_v;
   assign seg_n      = r_seg;
   assign dig_en_n   = r_dig;
   assign frame_done = w_frame_last;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: arithmetic scan model plus directed
// literal checks and a randomized load/brightness phase.
module tb_seg_scan_driver;

   localparam int DC = 40;
   localparam int BC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [47:0] display_bits = '0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [3:0]  brightness = 4'hF;
   logic [7:0]  seg_n;
   logic [5:0]  dig_en_n;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   seg_scan_driver #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .display_bits (display_bits),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .brightness   (brightness),
      .seg_n        (seg_n),
      .dig_en_n     (dig_en_n),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   // Model: t = cycles since reset release; slot/pos from plain division
   int          m_t;
   logic [47:0] m_act;
   logic [47:0] m_pend;
   logic        m_pv;
   logic [3:0]  m_lvl;

   function automatic int slot_of(int t);
      return (t / DC) % 6;
   endfunction

   function automatic int pos_of(int t);
      return t % DC;
   endfunction

   function automatic logic boundary(int t);
      return (slot_of(t) == 5) && (pos_of(t) == DC - 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t    <= 0;
         m_act  <= '1;
         m_pend <= '0;
         m_pv   <= 1'b0;
         m_lvl  <= 4'd0;
      end else begin
         m_t <= m_t + 1;
         if ((m_t + 1) % DC == BC) m_lvl <= brightness;
         if (boundary(m_t) && m_pv) begin
            m_act <= m_pend;
            m_pv  <= 1'b0;
         end
         if (load_valid && !m_pv) begin
            m_pend <= display_bits;
            m_pv   <= 1'b1;
         end
      end
   end

   function automatic logic exp_en();
      int p;
      int pc;
      p  = pos_of(m_t);
      pc = (p - BC) % 16;
      return (p >= BC) && ((m_lvl == 4'hF) || (pc < int'(m_lvl)));
   endfunction

   function automatic logic [7:0] exp_seg();
      logic [47:0] s;
      s = m_act >> (8 * slot_of(m_t));
      return exp_en() ? s[7:0] : 8'hFF;
   endfunction

   function automatic logic [5:0] exp_dig();
      logic [5:0] one;
      one = 6'd1 << slot_of(m_t);
      return exp_en() ? (6'h3F & ~one) : 6'h3F;
   endfunction

   task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0d: got %h expected %h",
                  name, m_t, act, exp);
      end
   endtask

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_seg", {40'd0, seg_n}, 48'hFF);
         chk("rst_dig", {42'd0, dig_en_n}, 48'h3F);
         chk("rst_fd", {47'd0, frame_done}, 48'd0);
         chk("rst_rdy", {47'd0, load_ready}, 48'd1);
      end else begin
         chk("seg", {40'd0, seg_n}, {40'd0, exp_seg()});
         chk("dig", {42'd0, dig_en_n}, {42'd0, exp_dig()});
         chk("fd", {47'd0, frame_done}, {47'd0, boundary(m_t)});
         chk("rdy", {47'd0, load_ready}, {47'd0, !m_pv});
      end
   end

   // Advance to posedge+2 of cycle n (n must be ahead of m_t)
   task automatic goto(int n);
      int g;
      g = 0;
      while (m_t < n && g < 5000) begin
         @(posedge clk);
         #1;
         g++;
      end
      #1;
      if (g >= 5000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL goto_timeout t=%0d: got stuck expected %0d",
                  m_t, n);
      end
   endtask

   localparam logic [47:0] FA = 48'h0102_0304_0506;
   localparam logic [47:0] FB = 48'h1112_1314_1516;
   localparam logic [47:0] FC = 48'h2122_2324_2526;
   localparam logic [47:0] FD = 48'h3132_3334_3536;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("lit_rst_seg", {40'd0, seg_n}, 48'hFF);
      chk("lit_rst_rdy", {47'd0, load_ready}, 48'd1);
      rst = 1'b0;
      display_bits = FA;
      load_valid = 1'b1;

      goto(1);
      display_bits = FB;
      chk("lit_rdy_drop", {47'd0, load_ready}, 48'd0);
      goto(100);
      chk("lit_backpress", {47'd0, load_ready}, 48'd0);
      goto(239);
      chk("lit_fd_239", {47'd0, frame_done}, 48'd1);
      goto(240);
      chk("lit_rdy_240", {47'd0, load_ready}, 48'd1);
      goto(241);
      chk("lit_rdy_241", {47'd0, load_ready}, 48'd0);
      load_valid = 1'b0;
      goto(242);
      chk("lit_blank_seg", {40'd0, seg_n}, 48'hFF);
      chk("lit_blank_dig", {42'd0, dig_en_n}, 48'h3F);
      goto(250);
      chk("lit_d0_seg", {40'd0, seg_n}, 48'h06);
      chk("lit_d0_dig", {42'd0, dig_en_n}, 48'h3E);
      goto(450);
      chk("lit_d5_seg", {40'd0, seg_n}, 48'h01);
      chk("lit_d5_dig", {42'd0, dig_en_n}, 48'h1F);
      goto(478);
      chk("lit_fd_478", {47'd0, frame_done}, 48'd0);
      goto(490);
      chk("lit_b_seg", {40'd0, seg_n}, 48'h16);

      goto(719);
      chk("lit_rdy_719", {47'd0, load_ready}, 48'd1);
      display_bits = FC;
      load_valid = 1'b1;
      goto(720);
      load_valid = 1'b0;
      goto(730);
      chk("lit_bnd_old", {40'd0, seg_n}, 48'h16);
      goto(970);
      chk("lit_bnd_new", {40'd0, seg_n}, 48'h26);

      goto(1190);
      brightness = 4'd0;
      goto(1250);
      chk("lit_lvl0_dig", {42'd0, dig_en_n}, 48'h3F);
      goto(1430);
      brightness = 4'd4;
      goto(1447);
      chk("lit_lvl4_on", {42'd0, dig_en_n}, 48'h3E);
      chk("lit_lvl4_seg", {40'd0, seg_n}, 48'h26);
      goto(1448);
      chk("lit_lvl4_off", {42'd0, dig_en_n}, 48'h3F);
      goto(1450);
      brightness = 4'hF;
      goto(1452);
      chk("lit_mid_chg", {42'd0, dig_en_n}, 48'h3F);
      goto(1460);
      chk("lit_lvl4_wrap", {42'd0, dig_en_n}, 48'h3E);
      goto(1495);
      chk("lit_d1_dig", {42'd0, dig_en_n}, 48'h3D);
      chk("lit_d1_seg", {40'd0, seg_n}, 48'h25);

      goto(1700);
      display_bits = FD;
      load_valid = 1'b1;
      goto(1701);
      load_valid = 1'b0;
      goto(1810);
      chk("lit_d3_dig", {42'd0, dig_en_n}, 48'h37);
      chk("lit_d3_seg", {40'd0, seg_n}, 48'h23);
      rst = 1'b1;
      #1;
      chk("lit_async_seg", {40'd0, seg_n}, 48'hFF);
      chk("lit_async_dig", {42'd0, dig_en_n}, 48'h3F);
      chk("lit_async_rdy", {47'd0, load_ready}, 48'd1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      goto(2);
      chk("lit_post_blank", {42'd0, dig_en_n}, 48'h3F);
      goto(10);
      chk("lit_post_seg", {40'd0, seg_n}, 48'hFF);
      chk("lit_post_dig", {42'd0, dig_en_n}, 48'h3E);
      goto(250);
      chk("lit_discard", {40'd0, seg_n}, 48'hFF);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         load_valid = ($urandom % 5) == 0;
         display_bits = {16'($urandom), 32'($urandom)};
         if ($urandom % 25 == 0)
            brightness = 4'($urandom_range(0, 15));
      end
      load_valid = 1'b0;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Receive side of the 48-bit six-digit display word produced by the lab ALU display path.
- Latches a frame through a valid/ready load handshake and time-multiplexes the six 8-bit segment patterns onto one shared segment bus with one-hot digit enables.
- Inserts an anti-ghosting blank interval at each digit slot and applies 4-bit PWM brightness.
- Sits between the display encoder output and the board's multiplexed seven-segment pins.

Parameters:
- DIGIT_CYCLES, 50000, clock cycles per digit slot (blank plus show); must satisfy DIGIT_CYCLES > BLANK_CYCLES + 16.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits disabled; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- display_bits  in  48  frame; byte i = bits[8i+7:8i] drives digit i (digit 0 rightmost); active-low segment pattern, DP in bit 7
- load_valid  in  1  frame offered
- load_ready  out  1  pending buffer empty; load accepted when load_valid && load_ready
- brightness  in  4  PWM level, 0 = off, 15 = full on
- seg_n  out  8  shared active-low segment bus
- dig_en_n  out  6  active-low one-hot digit enable
- frame_done  out  1  one-cycle pulse in the last cycle of digit 5's slot

Behaviour:
- Reset (async assert, sync release). Active frame = all bytes 8'hFF. Pending buffer empty. Digit index 0, state BLANK, slot counter 0.
- Output values during and after reset: seg_n=8'hFF, dig_en_n=6'h3F, frame_done=0, load_ready=1. Loads while rst is high are ignored.
- Registers: active frame (48 bits), pending frame (48 bits) plus pending_valid flag. load_ready = !pending_valid.
- Load acceptance: an accepted load writes pending and sets pending_valid on the next edge.
- Frame boundary: the last cycle of digit 5's slot. frame_done=1 in that cycle. If pending_valid, active <= pending and pending_valid clears on that edge.
- Load in the boundary cycle: if pending was empty in the boundary cycle and a load is accepted then, the data lands in pending and is applied at the following boundary.
- No tearing: the active frame never changes mid-frame.
- Slot FSM, per slot:
  - BLANK lasts BLANK_CYCLES cycles, then transitions to SHOW.
  - SHOW lasts DIGIT_CYCLES - BLANK_CYCLES cycles.
  - On the slot's last cycle, move to BLANK and advance the digit index 0→1→…→5→0.
- Brightness is sampled into a slot register on entry to SHOW.
- pwm_cnt is a 4-bit counter, reset to 0 on SHOW entry and incrementing each SHOW cycle (wraps 15→0).
- Digit enable: the digit is enabled when (lvl==15) || (pwm_cnt < lvl).
- Outputs in SHOW with digit enabled: seg_n = active byte[index]; dig_en_n has bit[index]=0, all other bits 1.
- Outputs otherwise (BLANK, or PWM off): seg_n=8'hFF, dig_en_n=6'h3F.
- Output timing: all outputs are registered and reflect the current state/counter in the same cycle (next-state decoded into output flops). There are never two digits enabled at once, and never a digit enabled with a stale seg_n.
- First slot: digit 0's slot starts in the first cycle after reset release.
- Reset mid-frame: immediate return to reset values; any pending frame is discarded.
- load_valid may drop without acceptance; no data is captured unless the handshake fires.

Decomposition:
- seg_pkg holds:
  - NUM_DIGITS=6, SEG_W=8, SEG_BLANK=8'hFF, DIG_OFF=6'h3F
  - typedef enum {BLANK, SHOW} scan_state_t
  - typedef logic [SEG_W-1:0] seg_t
- One sub-module, seg_slot_timer: owns the slot counter, FSM state and pwm_cnt. It emits show, pwm_on, slot_last and frame_last. The top level owns the frame buffers, handshake and output muxing.

Test Plan (DIGIT_CYCLES=40, BLANK_CYCLES=4):
1. Reset, then load 48'h0102_0304_0506 with brightness=15 → load_ready drops 1 cycle. After the first frame_done, the next frame shows digit 0 with seg_n=8'h06 and dig_en_n=6'h3E for 36 cycles, then digit 5 (in its own slot) shows 8'h01 with dig_en_n=6'h1F.
2. Scan timing → each slot is exactly 4 cycles of seg_n=FF/dig_en_n=3F followed by 36 enabled cycles. frame_done pulses every 240 cycles; the digit order is 0..5 and wraps.
3. Back-pressure: accept frame A, then hold frame B on load_valid → load_ready=0 until A is promoted at the boundary. B is accepted the cycle after and appears one frame later. A is not corrupted.
4. Brightness: level 0 → dig_en_n stays 3F the whole frame. Level 4 → the enable is asserted in SHOW cycles with pwm_cnt 0–3 only (4 of every 16 cycles). Changing brightness mid-SHOW has no effect until the next slot.
5. Load accepted exactly in the boundary cycle with pending empty → not displayed in the next frame; displayed in the frame after.
6. Assert rst during digit 3 SHOW with a pending frame held → outputs go to FF/3F asynchronously. After release, digit 0 starts blank and the active frame is all 8'hFF until a new load is promoted.
